// File: rtl/exhaustive_bist.sv
// Exhaustive BIST controller: sweeps every input pattern of a small combinational
// unit, folds each response into a rotate-XOR signature and checks it against a golden value.
module exhaustive_bist #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SIG_W-1:0]   expected_sig,
  input  logic [N_OUT-1:0]   resp_in,
  output logic [N_IN-1:0]    pat_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [SIG_W-1:0]   signature,
  output logic [N_IN:0]      pat_count
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  // With no settle time every pattern is sampled in the cycle it is applied.
  localparam state_t     FIRST_ST    = (SETTLE > 0) ? APPLY : SAMPLE;
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    pat_q, pat_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [SIG_W-1:0]   golden_q, golden_d;
  logic [N_IN:0]      cnt_q, cnt_d;
  logic [7:0]         settle_q, settle_d;
  logic               pass_q, pass_d;
  logic [SIG_W-1:0]   sig_next;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    sig_d    = sig_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    sig_next = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(resp_in);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          golden_d = expected_sig;
          sig_d    = '0;
          cnt_d    = '0;
          pat_d    = '0;
          settle_d = '0;
          pass_d   = 1'b0;
          state_d  = FIRST_ST;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      SAMPLE: begin
        sig_d = sig_next;
        cnt_d = cnt_q + (N_IN+1)'(1);
        if (pat_q == '1) begin
          pass_d  = (sig_next == golden_q);
          state_d = DONE;
        end else begin
          pat_d    = pat_q + N_IN'(1);
          settle_d = '0;
          state_d  = FIRST_ST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      sig_q    <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      sig_q    <= sig_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
    end
  end

  assign pat_out   = pat_q;
  assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q && (state_q == DONE);
  assign signature = sig_q;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_exhaustive_bist.sv
// Directed bench for exhaustive_bist: default configuration with resp_in = pat_out[1:0],
// plus an N_IN=4 / SETTLE=0 instance with resp_in tied low.
module tb_exhaustive_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected_sig;
  logic [1:0]  resp_in;
  logic [2:0]  pat_out;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [3:0]  pat_count;

  logic        start0;
  logic [15:0] expected_sig0;
  logic [3:0]  pat_out0;
  logic        busy0, done0, pass0;
  logic [15:0] signature0;
  logic [4:0]  pat_count0;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  assign resp_in = pat_out[1:0];

  exhaustive_bist dut (
    .clk(clk), .rst(rst), .start(start), .expected_sig(expected_sig),
    .resp_in(resp_in), .pat_out(pat_out), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .pat_count(pat_count)
  );

  exhaustive_bist #(.N_IN(4), .N_OUT(2), .SETTLE(0), .SIG_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected_sig(expected_sig0),
    .resp_in(2'b00), .pat_out(pat_out0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(signature0), .pat_count(pat_count0)
  );

  typedef struct {
    logic        start;
    logic [15:0] exp_in;
    logic [2:0]  pat;
    logic [15:0] sig;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [15:0] golden, input logic exp_pass);
    start = 1'b1;
    expected_sig = golden;
    step();
    start = 1'b0;
    expected_sig = 16'h0;
    chk("accept_busy", 32'(busy), 32'(1));
    chk("accept_done", 32'(done), 32'(0));
    chk("accept_pass", 32'(pass), 32'(0));
    chk("accept_sig", 32'(signature), 32'(0));
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start;
      expected_sig = tbl[i].exp_in;
      step();
      start = 1'b0;
      chk($sformatf("pat[%0d]", i), 32'(pat_out), 32'(tbl[i].pat));
      chk($sformatf("sig[%0d]", i), 32'(signature), 32'(tbl[i].sig));
      chk($sformatf("cnt[%0d]", i), 32'(pat_count), 32'(tbl[i].cnt));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("done[%0d]", i), 32'(done), 32'(tbl[i].done));
    end
    chk("final_pass", 32'(pass), 32'(exp_pass));
    step();
    chk("hold_done", 32'(done), 32'(1));
    chk("hold_sig", 32'(signature), 32'(16'h0033));
  endtask

  initial begin
    int cycles;
    // Entry i is observed i+1 edges after the start-accept edge; start pulses in
    // entries 5 and 10 land mid-sweep together with a bogus golden value.
    tbl[0]  = '{1'b0, 16'h0000, 3'd0, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 3'd1, 16'h0000, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 3'd1, 16'h0000, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 3'd2, 16'h0001, 4'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 3'd2, 16'h0001, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'hBEEF, 3'd3, 16'h0000, 4'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 3'd3, 16'h0000, 4'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 3'd4, 16'h0003, 4'd4, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 3'd4, 16'h0003, 4'd4, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 3'd5, 16'h0006, 4'd5, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h1234, 3'd5, 16'h0006, 4'd5, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 3'd6, 16'h000D, 4'd6, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 3'd6, 16'h000D, 4'd6, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 3'd7, 16'h0018, 4'd7, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 3'd7, 16'h0018, 4'd7, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 16'h0000, 3'd7, 16'h0033, 4'd8, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; expected_sig = '0;
    start0 = 1'b0; expected_sig0 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_pat", 32'(pat_out), 32'(0));
    chk("rst_sig", 32'(signature), 32'(0));
    chk("rst_cnt", 32'(pat_count), 32'(0));
    step();
    chk("idle_hold_busy", 32'(busy), 32'(0));

    run_sweep(16'h0033, 1'b1);
    run_sweep(16'h0034, 1'b0);
    run_sweep(16'h0033, 1'b1);

    // Reset in the 5th cycle of a sweep.
    start = 1'b1; expected_sig = 16'h0033;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_pat", 32'(pat_out), 32'(0));
    chk("midrst_sig", 32'(signature), 32'(0));
    chk("midrst_cnt", 32'(pat_count), 32'(0));
    run_sweep(16'h0033, 1'b1);

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1; expected_sig = 16'h0033;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'(0));
    chk("rst_start_done", 32'(done), 32'(0));
    step();
    chk("rst_start_idle", 32'(busy), 32'(0));

    // SETTLE=0, N_IN=4 instance: 16-cycle sweep, mid-sweep start ignored.
    start0 = 1'b1; expected_sig0 = 16'h0000;
    step();
    start0 = 1'b0; expected_sig0 = 16'hFFFF;
    chk("s0_accept_busy", 32'(busy0), 32'(1));
    cycles = 0;
    while (!done0 && cycles < 40) begin
      start0 = (cycles == 5 || cycles == 9);
      step();
      cycles++;
      if (cycles == 3) chk("s0_pat3", 32'(pat_out0), 32'(3));
    end
    start0 = 1'b0;
    chk("s0_cycles", 32'(cycles), 32'(16));
    chk("s0_done", 32'(done0), 32'(1));
    chk("s0_pass", 32'(pass0), 32'(1));
    chk("s0_sig", 32'(signature0), 32'(0));
    chk("s0_cnt", 32'(pat_count0), 32'(16));
    chk("s0_pat", 32'(pat_out0), 32'(15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/exhaustive_bist.md
Name: exhaustive_bist

Overview:
- Parametrised built-in self-test controller for small combinational blocks.
- Drives every input pattern 0 .. 2^N_IN-1 in ascending order into the unit under test and waits a programmable settle time per pattern.
- Folds each response into a signature register and compares the final signature against an expected value.
- Successor to the hand-written exhaustive truth-table sweeps used for 3-input logic blocks: arbitrary widths, hardware compaction, pass/fail flag.

Parameters:
- N_IN, 3, unit-under-test input width; legal range 1..16.
- N_OUT, 2, unit-under-test output width; legal range 1..SIG_W.
- SETTLE, 1, wait cycles between driving a pattern and sampling its response; legal range 0..255.
- SIG_W, 16, signature register width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- expected_sig  input  SIG_W  golden signature; sampled in the cycle start is accepted.
- resp_in  input  N_OUT  response from the unit under test.
- pat_out  output  N_IN  registered stimulus to the unit under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next accepted start or rst.
- pass  output  1  signature == golden; meaningful only while done=1, otherwise 0.
- signature  output  SIG_W  current signature register.
- pat_count  output  N_IN+1  number of patterns sampled so far.

Behaviour:
- Reset (rst=1 at a clock edge, in any state including mid-sweep):
  - State goes to IDLE.
  - pat_out=0, busy=0, done=0, pass=0, signature=0, pat_count=0, golden register=0, settle counter=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - Latch expected_sig into the golden register.
  - signature, pat_count, pat_out cleared to 0; done, pass cleared; busy=1.
  - Next state is APPLY if SETTLE>0, else SAMPLE.
- IDLE or DONE, start=0: hold state and all outputs.
- APPLY: settle counter counts SETTLE cycles (pat_out stable), then go to SAMPLE.
- SAMPLE (one cycle), at its closing edge:
  - signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} XOR zero-extended resp_in (rotate left by 1, then XOR).
  - pat_count <= pat_count+1.
  - If pat_out == 2^N_IN-1: go to DONE, busy=0, done=1, pass=(next signature == golden). pat_out holds its last value.
  - Otherwise: pat_out <= pat_out+1, settle counter cleared, go to APPLY (or stay in SAMPLE if SETTLE=0).
- Timing:
  - Each pattern occupies exactly SETTLE+1 cycles.
  - The response for a pattern is sampled SETTLE+1 edges after that pattern first appears on pat_out.
  - A sweep takes 2^N_IN*(SETTLE+1) cycles from the start-accept edge to done=1.
- pat_count is N_IN+1 bits, so it reaches 2^N_IN without wrapping. pat_out never wraps within a sweep.
- start while busy=1 is ignored. expected_sig changes during a sweep have no effect.
- rst and start asserted in the same cycle: rst wins, state is IDLE.
- start in DONE restarts cleanly: done deasserts on the accepting edge.

Test Plan:
- Defaults, resp_in tied to pat_out[1:0], start pulse with expected_sig=16'h0033:
  - pat_out steps 0..7, each held 2 cycles.
  - Per-sample signature 0,1,0,3,6,000D,0018,0033.
  - done=1 and pass=1 sixteen cycles after start accept; pat_count=8.
- Same stimulus with expected_sig=16'h0034: done=1, pass=0, signature=16'h0033.
- SETTLE=0, N_IN=4, resp_in tied to 0: sweep takes 16 cycles, signature=0, pass=1 with expected 0; start pulses mid-sweep are ignored.
- rst asserted on the 5th cycle of a default sweep:
  - Next edge: busy=0, pat_out=0, signature=0, pat_count=0.
  - A following start runs a full 16-cycle sweep giving 16'h0033.
- After done, a second start with the same stimulus: done drops on the accept edge, and the sweep reproduces 16'h0033 with pass=1.
- rst and start high together in IDLE: state stays IDLE, busy=0.
